mem_wrapper_pkt: RTL and testbench

Memory-wrapper-side NoC endpoint: the transmit/receive counterpart of the PE packet interface. On `start` it reads one filter row and one ifmap row per PE from local ROMs, packetizes them into the 33-bit PE packet format (filters first, then ifmaps), and injects them into the NoC. Concurrently it receives spike packets returned by PEs to address 13. It validates them, reports each spike and counts them. The round ends when the expected number of spikes has arrived.

---
 rtl/mem_wrapper_pkt.sv | 140 ++++++++++++++
 tb/tb_mem_wrapper_pkt.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wrapper_pkt.sv
// Memory-wrapper NoC endpoint: streams one filter row and one ifmap row per PE out of
// the local ROMs as 33-bit packets, and collects the spike packets the PEs send back.
module mem_wrapper_pkt #(
    parameter int         NUM_PE        = 4,
    parameter logic [3:0] MEM_ADDR      = 4'd13,
    parameter int         SPIKES_PER_PE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [3:0]  filt_raddr,
    input  logic [23:0] filt_rdata,
    output logic [3:0]  ifm_raddr,
    input  logic [8:0]  ifm_rdata,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [32:0] tx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [32:0] rx_data,
    output logic        spike_valid,
    output logic [3:0]  spike_pe,
    output logic        spike_bit,
    output logic        rx_err
);
    localparam logic [3:0] LAST_IDX = 4'(NUM_PE - 1);
    localparam logic [7:0] TARGET   = 8'(NUM_PE * SPIKES_PER_PE);

    typedef enum logic [2:0] {IDLE, RD0, RD1, TX, WAIT, DONE} state_t;

    state_t     state;
    logic       phase;
    logic [3:0] idx;
    logic [7:0] count;
    logic [7:0] count_next;
    logic       rx_hs;
    logic       pkt_ok;
    logic       spike_acc;

    // Both ROMs are addressed by the current PE index; phase only picks which one is packetized.
    assign filt_raddr = idx;
    assign ifm_raddr  = idx;

    assign rx_hs  = rx_valid && rx_ready;
    assign pkt_ok = !rx_data[32]
                 && (rx_data[31:28] == MEM_ADDR)
                 && ({1'b0, rx_data[27:24]} < 5'(NUM_PE))
                 && (rx_data[23:1] == 23'd0);

    // The count saturates at the target and ignores spikes that arrive outside a round.
    assign spike_acc  = rx_hs && pkt_ok && busy && (count < TARGET);
    assign count_next = count + {7'd0, spike_acc};

    // NOTE: all state here is updated with non-blocking assignments so every branch
    // sees the pre-edge values of state, idx and count regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            phase    <= 1'b0;
            idx      <= 4'd0;
            count    <= 8'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= 33'd0;
        end else begin
            done  <= 1'b0;
            count <= count_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        phase <= 1'b0;
                        idx   <= 4'd0;
                        count <= 8'd0;
                        busy  <= 1'b1;
                        state <= RD0;
                    end
                end
                RD0: state <= RD1;
                RD1: begin
                    tx_valid <= 1'b1;
                    tx_data  <= phase ? {1'b1, idx, MEM_ADDR, 15'd0, ifm_rdata}
                                      : {1'b0, idx, MEM_ADDR, filt_rdata};
                    state    <= TX;
                end
                TX: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (idx < LAST_IDX) begin
                            idx   <= idx + 4'd1;
                            state <= RD0;
                        end else if (!phase) begin
                            phase <= 1'b1;
                            idx   <= 4'd0;
                            state <= RD0;
                        end else if (count_next == TARGET) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (count_next == TARGET) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Receive path: always ready, one-cycle report of every accepted packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready    <= 1'b0;
            spike_valid <= 1'b0;
            spike_pe    <= 4'd0;
            spike_bit   <= 1'b0;
            rx_err      <= 1'b0;
        end else begin
            rx_ready    <= 1'b1;
            spike_valid <= rx_hs && pkt_ok;
            rx_err      <= rx_hs && !pkt_ok;
            if (rx_hs && pkt_ok) begin
                spike_pe  <= rx_data[27:24];
                spike_bit <= rx_data[0];
            end
        end
    end

endmodule

// File: tb/tb_mem_wrapper_pkt.sv
// Self-checking bench for mem_wrapper_pkt: directed rounds plus a randomized round,
// compared against a packet-list / spike-list reference built from the packet rules.
module tb_mem_wrapper_pkt;
    localparam int         NUM_PE = 4;
    localparam logic [3:0] MEM    = 4'd13;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [3:0]  filt_raddr;
    logic [23:0] filt_rdata;
    logic [3:0]  ifm_raddr;
    logic [8:0]  ifm_rdata;
    logic        tx_valid;
    logic        tx_ready;
    logic [32:0] tx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [32:0] rx_data;
    logic        spike_valid;
    logic [3:0]  spike_pe;
    logic        spike_bit;
    logic        rx_err;

    mem_wrapper_pkt #(.NUM_PE(NUM_PE), .MEM_ADDR(MEM), .SPIKES_PER_PE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .filt_raddr(filt_raddr), .filt_rdata(filt_rdata),
        .ifm_raddr(ifm_raddr), .ifm_rdata(ifm_rdata),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .spike_valid(spike_valid), .spike_pe(spike_pe), .spike_bit(spike_bit),
        .rx_err(rx_err)
    );

    always #5 clk = ~clk;

    // Synchronous-read ROMs: address sampled on the edge, data valid after it.
    logic [23:0] filt_rom [16];
    logic [8:0]  ifm_rom  [16];
    always @(posedge clk) begin
        filt_rdata <= filt_rom[filt_raddr];
        ifm_rdata  <= ifm_rom[ifm_raddr];
    end

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Observation log, sampled on the falling edge.
    logic [32:0] tx_q [$];
    int          tx_cyc [$];
    logic [4:0]  spk_q [$];
    int          err_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          stab_err = 0;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_data = 33'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!tx_valid || tx_data !== prev_data)) stab_err++;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (tx_valid && tx_ready) begin
                tx_q.push_back(tx_data);
                tx_cyc.push_back(cyc);
            end
            if (spike_valid) spk_q.push_back({spike_pe, spike_bit});
            if (rx_err) err_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: k-th packet of a round, filters 0..NUM_PE-1 then ifmaps.
    function automatic logic [32:0] exp_pkt(input int k);
        if (k < NUM_PE) return {1'b0, 4'(k), MEM, filt_rom[k]};
        return {1'b1, 4'(k - NUM_PE), MEM, 15'd0, ifm_rom[k - NUM_PE]};
    endfunction

    function automatic logic [32:0] mk_spk(input logic [3:0] pe, input logic b);
        return {1'b0, MEM, pe, 23'd0, b};
    endfunction

    task automatic send_rx(input logic [32:0] pkt);
        rx_valid = 1'b1;
        rx_data  = pkt;
        tick();
        rx_valid = 1'b0;
        rx_data  = 33'd0;
    endtask

    task automatic wait_pkts(input string tag, input int target);
        for (int i = 0; i < 500 && tx_q.size() < target; i++) tick();
        check(tag, 64'(tx_q.size()), 64'(target));
    endtask

    task automatic check_reset_outputs(input string p);
        check({p, "_tx_valid"},    64'(tx_valid),    64'd0);
        check({p, "_tx_data"},     64'(tx_data),     64'd0);
        check({p, "_busy"},        64'(busy),        64'd0);
        check({p, "_done"},        64'(done),        64'd0);
        check({p, "_filt_raddr"},  64'(filt_raddr),  64'd0);
        check({p, "_ifm_raddr"},   64'(ifm_raddr),   64'd0);
        check({p, "_spike_valid"}, 64'(spike_valid), 64'd0);
        check({p, "_spike_pe"},    64'(spike_pe),    64'd0);
        check({p, "_spike_bit"},   64'(spike_bit),   64'd0);
        check({p, "_rx_err"},      64'(rx_err),      64'd0);
        check({p, "_rx_ready"},    64'(rx_ready),    64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [3:0]  order [4] = '{4'd0, 4'd2, 4'd1, 4'd3};
    logic [3:0]  perm  [4];
    logic [32:0] rx_list [$];
    logic [4:0]  exp_spk [$];

    initial begin
        int tb, sb, eb, db, stb, t0;
        logic [32:0] bad;
        rst_n = 1'b0; start = 1'b0; tx_ready = 1'b1; rx_valid = 1'b0; rx_data = 33'd0;
        for (int i = 0; i < 16; i++) begin
            filt_rom[i] = 24'h030201 + 24'(i);
            ifm_rom[i]  = 9'h1FF;
        end
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();
        check("rx_ready_rise", 64'(rx_ready), 64'd1);

        // Round A: no backpressure, spikes after the last ifmap, malformed packets in WAIT.
        tb = tx_q.size(); sb = spk_q.size(); eb = err_cnt; db = done_cnt;
        t0 = cyc;
        start = 1'b1; tick(); start = 1'b0;
        check("A_busy_rd0", 64'(busy), 64'd1);
        wait_pkts("A_pkt_count", tb + 8);
        check("A_first_literal", 64'(tx_q[tb]), 64'h0_0D03_0201);
        check("A_fifth_literal", 64'(tx_q[tb + 4]), 64'h1_0D00_01FF);
        check("A_start_latency", 64'(tx_cyc[tb] - t0), 64'd3);
        for (int k = 0; k < 8; k++)
            check($sformatf("A_pkt%0d", k), 64'(tx_q[tb + k]), 64'(exp_pkt(k)));
        for (int k = 1; k < 8; k++)
            check($sformatf("A_gap%0d", k), 64'(tx_cyc[tb + k] - tx_cyc[tb + k - 1]), 64'd3);
        check("A_busy_wait", 64'(busy), 64'd1);

        send_rx({1'b0, 4'h5, 4'd0, 24'd0});
        check("A_err_dst", 64'({rx_err, spike_valid}), 64'b10);
        send_rx({1'b0, MEM, 4'd9, 24'd0});
        check("A_err_src", 64'({rx_err, spike_valid}), 64'b10);
        send_rx({1'b1, MEM, 4'd0, 24'd0});
        check("A_err_type", 64'({rx_err, spike_valid}), 64'b10);
        tick();
        check("A_err_count", 64'(err_cnt - eb), 64'd3);
        check("A_no_spike", 64'(spk_q.size() - sb), 64'd0);
        check("A_not_done", 64'({busy, 1'(done_cnt - db)}), 64'b10);

        for (int i = 0; i < 4; i++) begin
            if (i == 3) check("A_done_before_last", 64'(done), 64'd0);
            send_rx(mk_spk(order[i], order[i][1]));
            check($sformatf("A_spike%0d", i), 64'({spike_valid, spike_pe, spike_bit}),
                  64'({1'b1, order[i], order[i][1]}));
        end
        check("A_done_pulse", 64'(done), 64'd1);
        tick();
        check("A_done_low", 64'(done), 64'd0);
        check("A_idle", 64'(busy), 64'd0);
        check("A_done_count", 64'(done_cnt - db), 64'd1);

        // Round B: random ROMs, 5-cycle stall on packet 2 with all spikes arriving meanwhile.
        for (int i = 0; i < 16; i++) begin
            filt_rom[i] = 24'($urandom);
            ifm_rom[i]  = 9'($urandom);
        end
        tb = tx_q.size(); db = done_cnt; stb = stab_err;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 20 && !(tx_valid && tx_q.size() == tb + 1); i++) tick();
        check("B_second_visible", 64'(tx_valid), 64'd1);
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                send_rx(mk_spk(4'(3 - i), 1'b1));
                check($sformatf("B_spike%0d", i), 64'({spike_valid, spike_pe}), 64'({1'b1, 4'(3 - i)}));
            end else begin
                tick();
            end
            check($sformatf("B_hold%0d", i), 64'({tx_valid, tx_data}), 64'({1'b1, exp_pkt(1)}));
        end
        tx_ready = 1'b1;
        wait_pkts("B_pkt_count", tb + 8);
        check("B_done_direct", 64'(done), 64'd1);
        tick();
        for (int k = 0; k < 8; k++)
            check($sformatf("B_pkt%0d", k), 64'(tx_q[tb + k]), 64'(exp_pkt(k)));
        check("B_done_after_last_tx", 64'(done_cyc - tx_cyc[tb + 7]), 64'd1);
        check("B_done_count", 64'(done_cnt - db), 64'd1);
        check("B_stable", 64'(stab_err - stb), 64'd0);
        check("B_idle", 64'(busy), 64'd0);

        // Round C: random ROMs, random backpressure, random spike order and malformed traffic.
        for (int i = 0; i < 16; i++) begin
            filt_rom[i] = 24'($urandom);
            ifm_rom[i]  = 9'($urandom);
        end
        for (int i = 0; i < 4; i++) perm[i] = 4'(i);
        for (int i = 3; i > 0; i--) begin
            int j;
            logic [3:0] t;
            j = $urandom_range(0, i);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        rx_list.delete(); exp_spk.delete();
        for (int i = 0; i < 4; i++) begin
            logic b;
            b = 1'($urandom);
            rx_list.push_back(mk_spk(perm[i], b));
            exp_spk.push_back({perm[i], b});
        end
        for (int m = 0; m < 3; m++) begin
            case ($urandom_range(0, 3))
                0:       bad = {1'b0, 4'($urandom_range(0, 12)), 4'd1, 24'd0};
                1:       bad = {1'b0, MEM, 4'($urandom_range(4, 15)), 24'd0};
                2:       bad = {1'b1, MEM, 4'd2, 24'd1};
                default: bad = {1'b0, MEM, 4'd0, 24'd2 << $urandom_range(0, 22)};
            endcase
            rx_list.insert($urandom_range(0, rx_list.size()), bad);
        end
        tb = tx_q.size(); sb = spk_q.size(); eb = err_cnt; db = done_cnt; stb = stab_err;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 800; i++) begin
            tx_ready = ($urandom_range(0, 3) != 0);
            if (rx_list.size() > 0 && $urandom_range(0, 2) == 0) begin
                rx_valid = 1'b1;
                rx_data  = rx_list.pop_front();
            end else begin
                rx_valid = 1'b0;
            end
            tick();
            if (done_cnt > db && rx_list.size() == 0) break;
        end
        rx_valid = 1'b0; rx_data = 33'd0; tx_ready = 1'b1;
        tick(); tick();
        check("C_pkt_count", 64'(tx_q.size() - tb), 64'd8);
        for (int k = 0; k < 8 && tb + k < tx_q.size(); k++)
            check($sformatf("C_pkt%0d", k), 64'(tx_q[tb + k]), 64'(exp_pkt(k)));
        check("C_spike_count", 64'(spk_q.size() - sb), 64'd4);
        for (int k = 0; k < 4 && sb + k < spk_q.size(); k++)
            check($sformatf("C_spike%0d", k), 64'(spk_q[sb + k]), 64'(exp_spk[k]));
        check("C_err_count", 64'(err_cnt - eb), 64'd3);
        check("C_done_count", 64'(done_cnt - db), 64'd1);
        check("C_stable", 64'(stab_err - stb), 64'd0);
        check("C_idle", 64'(busy), 64'd0);

        // Round D: reset while in TX, then a fresh round from filter idx 0.
        start = 1'b1; tick(); start = 1'b0;
        send_rx(mk_spk(4'd1, 1'b1));
        for (int i = 0; i < 10 && !tx_valid; i++) tick();
        check("D_in_tx", 64'({tx_valid, busy}), 64'b11);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("D_rst");
        tick();
        rst_n = 1'b1;
        tick();
        check("D_rx_ready", 64'(rx_ready), 64'd1);
        tb = tx_q.size(); db = done_cnt;
        start = 1'b1; tick(); start = 1'b0;
        wait_pkts("D_first_count", tb + 1);
        check("D_first_pkt", 64'(tx_q[tb]), 64'(exp_pkt(0)));
        wait_pkts("D_pkt_count", tb + 8);
        for (int i = 0; i < 4; i++) send_rx(mk_spk(4'(i), 1'b0));
        check("D_done_pulse", 64'(done), 64'd1);
        tick();
        check("D_done_count", 64'(done_cnt - db), 64'd1);
        check("D_idle", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
